// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, picks increment / branch-LUT target / halt,
// and runs a start/done handshake. Optional cycle counter enabled by FETCH_CYCLE_COUNT_EN.
module fetch_sequencer #(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned PROG_LEN = 1024
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic [8:0]      instr_i,
  input  logic            ctrl_branch_i,
  input  logic            cond_flag_i,
  input  logic            lut_we_i,
  input  logic [3:0]      lut_waddr_i,
  input  logic [PC_W-1:0] lut_wdata_i,
  output logic [PC_W-1:0] pc_o,
`ifdef FETCH_CYCLE_COUNT_EN
  output logic [31:0]     cycle_count_o,
`endif
  output logic            running_o,
  output logic            done_o
);

  localparam logic [PC_W-1:0] LastPc = PC_W'(PROG_LEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            running_q, done_q;
  logic [PC_W-1:0] lut_q [16];

  logic halt, branch_taken, start_accept;

  // Halt reuses the unused I-type slot.
  assign halt         = instr_i[8] && (instr_i[2:0] == 3'b110);
  // J (instr[0]) is unconditional; BR depends on the compare result.
  assign branch_taken = ctrl_branch_i && (instr_i[0] || cond_flag_i);
  // start is only honoured outside RUN.
  assign start_accept = start_i && (state_q != StRun);

  // Next-state and next-PC selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d = StRun;
          pc_d    = '0;
        end
      end
      StRun: begin
        if (!stall_i) begin
          if (halt) begin
            state_d = StDone;
          end else if (branch_taken) begin
            pc_d = lut_q[instr_i[7:4]];
          end else if (pc_q >= LastPc) begin
            // Run-off-end: stop rather than wrap.
            state_d = StDone;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, PC and registered status decodes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= (state_d == StRun);
      done_q    <= (state_d == StDone);
    end
  end

  // Branch-target LUT; a same-cycle read sees the old entry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 16; i++) lut_q[i] <= '0;
    end else if (lut_we_i) begin
      lut_q[lut_waddr_i] <= lut_wdata_i;
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [31:0] cycle_count_q;

  // Saturating count of RUN cycles, stalled or not.
  always_ff @(posedge clk_i) begin
    if (reset_i || start_accept) begin
      cycle_count_q <= '0;
    end else if ((state_q == StRun) && (cycle_count_q != '1)) begin
      cycle_count_q <= cycle_count_q + 32'd1;
    end
  end

  assign cycle_count_o = cycle_count_q;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
`endif

  assign pc_o      = pc_q;
  assign running_o = running_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer (PROG_LEN=8): vector table plus hand sequences,
// with expected outputs queued as each cycle's stimulus is driven.
module tb_fetch_sequencer;

  localparam int unsigned PC_W     = 10;
  localparam int unsigned PROG_LEN = 8;

  logic            clk = 1'b0;
  logic            reset, start, stall, ctrl_branch, cond_flag, lut_we;
  logic [8:0]      instr;
  logic [3:0]      lut_waddr;
  logic [PC_W-1:0] lut_wdata;
  logic [PC_W-1:0] pc;
  logic            running, done;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [31:0]     cycle_count;
`endif

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_W(PC_W), .PROG_LEN(PROG_LEN)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .stall_i       (stall),
    .instr_i       (instr),
    .ctrl_branch_i (ctrl_branch),
    .cond_flag_i   (cond_flag),
    .lut_we_i      (lut_we),
    .lut_waddr_i   (lut_waddr),
    .lut_wdata_i   (lut_wdata),
    .pc_o          (pc),
`ifdef FETCH_CYCLE_COUNT_EN
    .cycle_count_o (cycle_count),
`endif
    .running_o     (running),
    .done_o        (done)
  );

  typedef struct {
    logic            rst, st, stl;
    logic [8:0]      ins;
    logic            br, cnd, we;
    logic [3:0]      wa;
    logic [PC_W-1:0] wd;
    logic [PC_W-1:0] epc;
    logic            erun, edone;
  } vec_t;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            run, done;
    int unsigned     cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Model of the cycle counter: counts cycles spent in RUN as seen by the expected outputs.
  logic        m_run  = 1'b0;
  int unsigned m_cnt  = 0;

  localparam logic [8:0] Nop  = 9'h000;
  localparam logic [8:0] Halt = 9'h106;  // 1_00000_110
  localparam logic [8:0] Br5  = 9'h05C;  // 0_0101_1100
  localparam logic [8:0] J5   = 9'h05D;  // 0_0101_1101
  localparam logic [8:0] J2   = 9'h02D;  // 0_0010_1101

  task automatic add(input logic rst, st, stl, input logic [8:0] ins, input logic br, cnd,
                     input logic we, input logic [3:0] wa, input logic [PC_W-1:0] wd,
                     input logic [PC_W-1:0] epc, input logic erun, edone);
    vec_t v;
    v.rst = rst; v.st = st; v.stl = stl; v.ins = ins; v.br = br; v.cnd = cnd;
    v.we = we; v.wa = wa; v.wd = wd; v.epc = epc; v.erun = erun; v.edone = edone;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic step(input string tag, input vec_t v);
    exp_t e;
    reset = v.rst; start = v.st; stall = v.stl; instr = v.ins; ctrl_branch = v.br;
    cond_flag = v.cnd; lut_we = v.we; lut_waddr = v.wa; lut_wdata = v.wd;
    if (v.rst || (v.st && !m_run)) m_cnt = 0;
    else if (m_run && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    m_run = v.rst ? 1'b0 : v.erun;
    e.pc = v.epc; e.run = v.erun; e.done = v.edone; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".pc"}, longint'(pc), longint'(e.pc));
    check({tag, ".running"}, longint'(running), longint'(e.run));
    check({tag, ".done"}, longint'(done), longint'(e.done));
`ifdef FETCH_CYCLE_COUNT_EN
    check({tag, ".cycle_count"}, longint'(cycle_count), longint'(e.cnt));
`endif
  endtask

  task automatic run_one(input string tag, input logic rst, st, stl, input logic [8:0] ins,
                         input logic br, cnd, input logic [PC_W-1:0] epc,
                         input logic erun, edone);
    vec_t v;
    v.rst = rst; v.st = st; v.stl = stl; v.ins = ins; v.br = br; v.cnd = cnd;
    v.we = 1'b0; v.wa = '0; v.wd = '0; v.epc = epc; v.erun = erun; v.edone = edone;
    step(tag, v);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; instr = '0; ctrl_branch = 1'b0;
    cond_flag = 1'b0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;

    //   rst st stl instr br cnd we wa wd    pc run done
    add(1, 0, 0, Nop, 0, 0, 0, 0, 0,     0, 0, 0);   // reset state
    add(0, 0, 0, Nop, 0, 0, 0, 0, 0,     0, 0, 0);   // idle holds
    add(0, 1, 0, Nop, 0, 0, 0, 0, 0,     0, 1, 0);   // start
    for (int i = 1; i <= 7; i++)
      add(0, 0, 0, Nop, 0, 0, 0, 0, 0,   PC_W'(i), 1, 0);
    add(0, 0, 0, Nop, 0, 0, 0, 0, 0,     7, 0, 1);   // run-off-end at PROG_LEN-1
    add(0, 0, 0, Nop, 0, 0, 0, 0, 0,     7, 0, 1);   // done held
    add(0, 1, 0, Nop, 0, 0, 0, 0, 0,     0, 1, 0);   // restart clears done
    add(0, 0, 0, Nop, 0, 0, 0, 0, 0,     1, 1, 0);
    add(0, 0, 0, Nop, 0, 0, 0, 0, 0,     2, 1, 0);
    add(0, 0, 0, Nop, 0, 0, 0, 0, 0,     3, 1, 0);
    add(0, 0, 0, Halt, 0, 0, 0, 0, 0,    3, 0, 1);   // halt at pc 3
    add(0, 0, 0, Nop, 0, 0, 0, 0, 0,     3, 0, 1);
    add(0, 1, 1, Nop, 0, 0, 1, 5, 40,    0, 1, 0);   // start beats stall; LUT[5]=40
    add(0, 1, 0, Nop, 0, 0, 0, 0, 0,     1, 1, 0);   // start ignored in RUN
    add(0, 0, 0, Nop, 0, 0, 0, 0, 0,     2, 1, 0);
    add(0, 0, 0, Br5, 1, 1, 0, 0, 0,     40, 1, 0);  // BR taken
    add(0, 0, 0, Nop, 0, 0, 0, 0, 0,     40, 0, 1);  // past end -> done
    add(0, 1, 0, Nop, 0, 0, 0, 0, 0,     0, 1, 0);
    add(0, 0, 0, Nop, 0, 0, 0, 0, 0,     1, 1, 0);
    add(0, 0, 0, Nop, 0, 0, 0, 0, 0,     2, 1, 0);
    add(0, 0, 0, Br5, 1, 0, 0, 0, 0,     3, 1, 0);   // BR not taken
    add(0, 0, 0, J5, 1, 0, 0, 0, 0,      40, 1, 0);  // J unconditional
    add(0, 0, 0, Nop, 0, 0, 0, 0, 0,     40, 0, 1);
    add(0, 1, 0, Nop, 0, 0, 0, 0, 0,     0, 1, 0);
    add(0, 0, 0, J5, 0, 1, 1, 2, 10,     1, 1, 0);   // no ctrl_branch; LUT[2]=10
    add(0, 0, 0, J2, 1, 0, 1, 2, 20,     10, 1, 0);  // collision reads old LUT[2]
    add(0, 0, 0, Nop, 0, 0, 0, 0, 0,     10, 0, 1);
    add(0, 1, 0, Nop, 0, 0, 0, 0, 0,     0, 1, 0);
    add(0, 0, 0, J2, 1, 0, 0, 0, 0,      20, 1, 0);  // new LUT[2] visible
    add(0, 0, 0, Halt, 0, 0, 0, 0, 0,    20, 0, 1);

    for (int i = 0; i < vecs.size(); i++) step($sformatf("vec%0d", i), vecs[i]);

    // Stall while halt is presented at pc 6.
    run_one("stl_start", 0, 1, 0, Nop, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 6; i++) run_one($sformatf("stl_inc%0d", i), 0, 0, 0, Nop, 0, 0,
                                         PC_W'(i), 1, 0);
    for (int i = 0; i < 3; i++) run_one($sformatf("stl_hold%0d", i), 0, 0, 1, Halt, 1, 1,
                                        6, 1, 0);
    run_one("stl_release", 0, 0, 0, Halt, 0, 0, 6, 0, 1);

    // Reset mid-run at pc 5 clears state and the LUT.
    run_one("rst_start", 0, 1, 0, Nop, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) run_one($sformatf("rst_inc%0d", i), 0, 0, 0, Nop, 0, 0,
                                         PC_W'(i), 1, 0);
    run_one("rst_apply", 1, 0, 0, Nop, 0, 0, 0, 0, 0);
    run_one("rst_restart", 0, 1, 0, Nop, 0, 0, 0, 1, 0);
    run_one("rst_inc1b", 0, 0, 0, Nop, 0, 0, 1, 1, 0);
    run_one("rst_inc2b", 0, 0, 0, Nop, 0, 0, 2, 1, 0);
    run_one("rst_lut5", 0, 0, 0, J5, 1, 0, 0, 1, 0);  // LUT[5] cleared -> pc 0
    for (int i = 1; i <= 7; i++) run_one($sformatf("rst_run%0d", i), 0, 0, 0, Nop, 0, 0,
                                         PC_W'(i), 1, 0);
    run_one("rst_end", 0, 0, 0, Nop, 0, 0, 7, 0, 1);
    run_one("rst_hold", 0, 0, 0, Nop, 0, 0, 7, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch stage directly upstream of the control decoder.
- Owns the program counter (PC) and drives the instruction-memory address.
- Takes back the fetched 9-bit instruction plus the decoder's branch signal, and selects the next PC: increment, branch-LUT target, or halt.
- Runs a start/done handshake with the testbench or top level.

Parameters:
- PC_W, 10, program counter width in bits.
- PROG_LEN, 1024, number of valid instruction addresses; must be ≤ 2^PC_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins execution at PC 0.
- stall  input  1  while high, hold PC and state.
- instr  input  9  instruction at the current pc, read combinationally from instruction memory.
- ctrl_branch  input  1  decoder branch flag (BR or J).
- cond_flag  input  1  branch condition, taken from the R0 compare result.
- lut_we  input  1  branch-target LUT write enable.
- lut_waddr  input  4  LUT entry to write.
- lut_wdata  input  PC_W  target address to store.
- pc  output  PC_W  current instruction address.
- running  output  1  high while in RUN.
- done  output  1  high in DONE; held until the next start.

Behaviour:
- Reset values: state=IDLE, pc=0, running=0, done=0, all 16 LUT entries=0.
- States: IDLE, RUN, DONE.
  - IDLE: on start=1, go to RUN next cycle with pc=0; otherwise hold.
  - RUN, stall=1: pc and state hold; halt and branch are not evaluated.
  - RUN, stall=0: priority is halt > branch > increment.
- Halt: instr[8]=1 and instr[2:0]=3'b110 (the unused I-type slot).
  - Go to DONE; pc holds at the halt address.
- Branch:
  - Taken when ctrl_branch=1 and either instr[0]=1 (J, unconditional) or cond_flag=1 (BR).
  - Next pc = LUT[instr[7:4]].
  - A BR with ctrl_branch=1 and cond_flag=0 falls through to increment.
- Increment: next pc = pc+1.
  - If the current pc equals PROG_LEN-1 and no branch is taken, go to DONE instead and pc holds (run-off-end).
  - pc never wraps to 0 implicitly.
- DONE: done=1, running=0, pc holds.
  - start=1 returns to RUN with pc=0; done clears in the same edge.
- start during RUN is ignored; start and stall together in IDLE/DONE: start wins (stall only affects RUN).
- Outputs: running and done are registered state decodes, valid the cycle after each transition.
- Latency: one cycle from instr/ctrl_branch sampling to the new pc.
- LUT write:
  - Accepted in any state, including during stall.
  - Written value is visible from the next cycle.
  - A same-cycle branch reading the entry being written uses the old value.
- Reset mid-RUN: returns to IDLE with pc=0 on that edge; LUT contents are cleared.
- Branch target ≥ PROG_LEN: pc loads the value as-is; the next increment from an address ≥ PROG_LEN-1 ends in DONE.

Optional Feature:
- Macro: FETCH_CYCLE_COUNT_EN.
- Defined:
  - Adds output cycle_count (32 bits).
  - Cleared by reset and by an accepted start.
  - Increments on every RUN cycle, stalled or not.
  - Saturates at 2^32-1 and holds its value in DONE.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Linear run: reset, start, instr=9'h000 (ADD) every cycle, PROG_LEN=8 → pc steps 0..7, done=1 the cycle after pc=7, pc stays 7.
- Halt: at pc=3 present instr=9'b1_xxxxx_110 → next cycle done=1, running=0, pc=3; a later start → pc=0, done=0.
- Branch: LUT[5]=10'd40.
  - At pc=2: instr=9'b0_0101_1100, ctrl_branch=1, cond_flag=1 → pc=40.
  - Repeat with cond_flag=0 → pc=3.
  - J encoding 9'b0_0101_1101 with cond_flag=0 → pc=40.
- Stall: stall=1 for 3 cycles at pc=6 while halt is presented → pc stays 6 and state stays RUN; release stall → done next cycle.
- LUT write collision: LUT[2]=10 written with value 20 in the same cycle a J reads LUT[2] → pc=10; a later J via LUT[2] → pc=20.
- Reset mid-run: assert reset at pc=5 → next cycle pc=0, running=0, LUT[5] reads 0. With FETCH_CYCLE_COUNT_EN: cycle_count=0 after reset, then equals the RUN-cycle count at done.
